// File: rtl/w0rm_peripheral_dma.sv
// Single-channel W0RM bus copy engine: read a word, write it back out, repeat.
// Optional response timeout is built when W0RM_DMA_TIMEOUT_EN is defined.
module w0rm_peripheral_dma #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   core_clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  src_addr_i,
  input  logic [ADDR_WIDTH-1:0]  dst_addr_i,
  input  logic [COUNT_WIDTH-1:0] word_count_i,
  input  logic                   src_inc_i,
  input  logic                   dst_inc_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [COUNT_WIDTH-1:0] words_done_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_data_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic                   mem_valid_o,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic                   mem_valid_i,
  output logic [2:0]             dbg_state_o
);

  // Handshake: mem_valid_o is a one-cycle request strobe qualified by
  // mem_read_o/mem_write_o; the responder answers each request with a single
  // mem_valid_i pulse at least one cycle later, and only one request is ever
  // outstanding, so mem_valid_i is honoured only in the two wait states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  src_q, dst_q, src_d, dst_d;
  logic [COUNT_WIDTH-1:0] remain_q, words_done_q;
  logic                   src_inc_q, dst_inc_q;
  logic                   busy_q, done_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [DATA_WIDTH-1:0]  mem_data_q;
  logic                   mem_read_q, mem_write_q, mem_valid_q;
  logic                   waiting;
  logic                   timeout;

  assign src_d   = src_inc_q ? src_q + ADDR_WIDTH'(4) : src_q;
  assign dst_d   = dst_inc_q ? dst_q + ADDR_WIDTH'(4) : dst_q;
  assign waiting = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);

`ifdef W0RM_DMA_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT_CYCLES);
  logic [WCW-1:0] wait_cnt_q;
  logic           error_q;

  // Counter sits at zero outside the wait states, so every wait starts fresh.
  assign timeout = waiting && !mem_valid_i && (wait_cnt_q == WCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      wait_cnt_q <= (waiting && !mem_valid_i && !timeout) ? wait_cnt_q + WCW'(1) : '0;
      if (state_q == S_IDLE && start_i) error_q <= 1'b0;
      else if (timeout)                 error_q <= 1'b1;
    end
  end
  assign error_o = error_q;
`else
  assign timeout = 1'b0;
  assign error_o = 1'b0;
`endif

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      remain_q     <= '0;
      words_done_q <= '0;
      src_inc_q    <= 1'b0;
      dst_inc_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_valid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            src_q        <= src_addr_i;
            dst_q        <= dst_addr_i;
            remain_q     <= word_count_i;
            src_inc_q    <= src_inc_i;
            dst_inc_q    <= dst_inc_i;
            words_done_q <= '0;
            if (word_count_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_RD_REQ;
              busy_q      <= 1'b1;
              mem_valid_q <= 1'b1;
              mem_read_q  <= 1'b1;
              mem_addr_q  <= src_addr_i;
            end
          end
        end
        S_RD_REQ: begin
          mem_valid_q <= 1'b0;
          mem_read_q  <= 1'b0;
          state_q     <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (mem_valid_i) begin
            mem_data_q  <= mem_data_i;
            mem_addr_q  <= dst_q;
            mem_valid_q <= 1'b1;
            mem_write_q <= 1'b1;
            state_q     <= S_WR_REQ;
          end else if (timeout) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_WR_REQ: begin
          mem_valid_q <= 1'b0;
          mem_write_q <= 1'b0;
          state_q     <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (mem_valid_i) begin
            words_done_q <= words_done_q + COUNT_WIDTH'(1);
            remain_q     <= remain_q - COUNT_WIDTH'(1);
            src_q        <= src_d;
            dst_q        <= dst_d;
            if (remain_q == COUNT_WIDTH'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q     <= S_RD_REQ;
              mem_valid_q <= 1'b1;
              mem_read_q  <= 1'b1;
              mem_addr_q  <= src_d;
            end
          end else if (timeout) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign words_done_o = words_done_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_valid_o  = mem_valid_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/w0rm_peripheral_dma.md
# w0rm_peripheral_dma

Single-channel bus-initiator copy engine for the W0RM peripheral bus. It generates the same read/write request strobes the CPU core drives and consumes the merged `mem_valid_i`/`mem_data_i` response stream from the bus extenders. Typical uses are moving blocks between core RAM and memory-mapped peripherals such as GPIO, independent of the CPU. Its master port joins the bus through the existing arbitration/muxing logic; this block does no arbitration.

## Interface
- `DATA_WIDTH`, 32, bus data width.
- `ADDR_WIDTH`, 32, bus address width.
- `COUNT_WIDTH`, 16, width of the word-count / progress counters.
- `TIMEOUT_CYCLES`, 64, maximum wait for a response, used only with `W0RM_DMA_TIMEOUT_EN`. Must be ≥2.
- `core_clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start_i` in 1: one-cycle start strobe. Ignored while `busy_o`=1.
- `src_addr_i` in ADDR_WIDTH: first source byte address, word aligned.
- `dst_addr_i` in ADDR_WIDTH: first destination byte address, word aligned.
- `word_count_i` in COUNT_WIDTH: number of words to copy.
- `src_inc_i` in 1: 1 advances the source address by 4 per word; 0 keeps it fixed.
- `dst_inc_i` in 1: 1 advances the destination address by 4 per word; 0 keeps it fixed.
- `busy_o` out 1: transfer in progress.
- `done_o` out 1: one-cycle completion pulse.
- `error_o` out 1: sticky; set on timeout, cleared by the next accepted start.
- `words_done_o` out COUNT_WIDTH: number of completed word writes.
- `mem_addr_o` out ADDR_WIDTH: request address.
- `mem_data_o` out DATA_WIDTH: write data.
- `mem_read_o` out 1: read request qualifier.
- `mem_write_o` out 1: write request qualifier.
- `mem_valid_o` out 1: one-cycle request strobe.
- `mem_data_i` in DATA_WIDTH: response data.
- `mem_valid_i` in 1: one-cycle response/acknowledge strobe.

## Operation
- All outputs are registered. Reset value of every output is 0. The FSM resets to IDLE.
- Bus rules:
  - At most one outstanding request.
  - Responders acknowledge both reads and writes with a one-cycle `mem_valid_i`.
  - A response arrives ≥1 cycle after its request.
- The start strobe latches `src_addr_i`, `dst_addr_i`, `word_count_i`, `src_inc_i` and `dst_inc_i`, clears `error_o` and `words_done_o`, and sets `busy_o`.
- FSM states and transitions:
  - IDLE → RD_REQ on `start_i` when the count is non-zero.
  - IDLE → DONE on `start_i` when the count is 0. No bus traffic is issued.
  - RD_REQ: `mem_valid_o`=1, `mem_read_o`=1, `mem_addr_o`=src for exactly one cycle. → RD_WAIT.
  - RD_WAIT: on `mem_valid_i`, capture `mem_data_i` into the data register. → WR_REQ.
  - WR_REQ: `mem_valid_o`=1, `mem_write_o`=1, `mem_addr_o`=dst, `mem_data_o`=captured word for one cycle. → WR_WAIT.
  - WR_WAIT: on `mem_valid_i`, increment `words_done_o`, decrement the remaining count, and step each address that has its increment enabled by +4 (wraps modulo 2^ADDR_WIDTH). Go to DONE if the remaining count reaches 0, else RD_REQ.
  - DONE: `done_o`=1 and `busy_o`=0 for one cycle. → IDLE.
- Strobe behaviour outside requests:
  - `mem_read_o` and `mem_write_o` are 0 whenever `mem_valid_o` is 0.
  - `mem_addr_o` and `mem_data_o` hold their last values.
- `mem_valid_i` is ignored in every state other than RD_WAIT and WR_WAIT. This covers stray responses to other initiators.
- A `start_i` during busy or DONE is dropped. It is not queued.
- Reset mid-transfer aborts immediately: no further strobes, all outputs 0.

## Timing
- Start is sampled at edge 0. The first read strobe is visible in the cycle after edge 0.
- With a responder latency of L cycles (request cycle to `mem_valid_i` cycle), each word takes 2·(L+1) cycles.
- `done_o` is asserted the cycle after the final write acknowledge.
- Total for N words is 1 + 2N(L+1) cycles from the start edge to `done_o`.
- Count 0: `done_o` is asserted in the cycle after the start edge.
- The `words_done_o` update is visible the cycle after the write acknowledge.

## Configuration
- `W0RM_DMA_TIMEOUT_EN` defined:
  - A wait counter runs in RD_WAIT and WR_WAIT. It is cleared on entry to either state.
  - If TIMEOUT_CYCLES cycles pass with no `mem_valid_i`, `error_o` is set and the FSM goes to DONE. `done_o` still pulses.
  - `words_done_o` reports the number of words that completed before the timeout.
- Undefined:
  - No counter is present, and `error_o` is tied to 0.
  - The FSM waits indefinitely for a response.

## Test plan
- Copy 4 words, src 0x100 → dst 0x200, both increment, RAM model with L=2: the destination holds the 4 source words, `words_done_o`=4, `done_o` 25 cycles after start, `error_o`=0.
- `word_count_i`=0: `done_o` pulse the cycle after start, no `mem_valid_o`, `words_done_o`=0.
- Copy 3 words to GPIO 0x80000040 with `dst_inc_i`=0: three writes, all to 0x80000040, carrying the source words in order.
- With the timeout macro, source at an unmapped address (no responder), TIMEOUT_CYCLES=64: `error_o`=1 and `done_o` asserted after the 64-cycle wait, `words_done_o`=0. A following valid start clears `error_o`.
- Second `start_i` mid-transfer with different addresses: it is ignored, and the original transfer completes unchanged.
- Reset asserted during WR_WAIT of word 2: all outputs 0 immediately, no further strobes. After release, a new start runs normally.
